ram_dp_init: RTL
================

# ram_dp_init

Single-clock simple dual-port RAM (one write port, one read port) and the parametrised successor to the team's dual-port RAM. It adds byte-lane write enables, a selectable read-during-write collision mode, a read-valid strobe, and a counter-driven clear engine that replaces the single-cycle bulk clear. It sits between packet buffers and their consumers wherever a shared, initialised scratch memory is needed.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: address width; DEPTH = 2**ADDR_WIDTH words.
- RDW_MODE, 0: read-during-write to the same address. 0 returns the old word; 1 returns the new word (write-through).
- INIT_VALUE, 0: DATA_WIDTH-wide value written to every word by the clear engine.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high; restarts the clear engine.
- we  in  1  write enable.
- be  in  DATA_WIDTH/8  byte-lane enables; bit k gates data_in[8k+7:8k].
- wr_addr  in  ADDR_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data.
- re  in  1  read enable.
- rd_addr  in  ADDR_WIDTH  read address.
- data_out  out  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  out  1  one-cycle strobe marking new data_out.
- init_busy  out  1  high while the clear engine owns the memory.

## Operation
Clear engine: a state machine with two states, CLEAR and READY.
- While rst is high:
  - state goes to CLEAR and the clear counter goes to 0.
  - init_busy is 1.
  - data_out, rd_valid and all pipeline registers are 0.
- In CLEAR with rst low, each cycle:
  - writes INIT_VALUE to mem[cnt] on all byte lanes;
  - increments cnt.
- When cnt = DEPTH-1 is written, the next state is READY and init_busy drops to 0. The clear takes exactly DEPTH cycles after rst falls.
- In CLEAR, we and re are ignored: no user write occurs and rd_valid stays 0.
- Asserting rst in any state, including mid-clear, aborts the sweep. The sweep restarts from address 0 after rst falls.

Write (READY only), when we=1:
- mem[wr_addr] byte lane k takes data_in lane k where be[k]=1; other lanes keep their value.
- If be is all zeros, the write is a no-op.

Read (READY only), when re=1:
- rd_addr is sampled and the word is returned (see Timing).
- When re=0, data_out holds and rd_valid=0.

Collision (we=1, re=1, wr_addr==rd_addr in the same cycle):
- RDW_MODE=0: data_out is the pre-write word.
- RDW_MODE=1: data_out is the merged word. Lanes with be=1 come from data_in; the other lanes come from the old word.
- The memory update is identical in both modes.

Address wrap: addresses are exactly ADDR_WIDTH bits. There is no out-of-range case.

## Timing
- Reset values:
  - data_out = 0
  - rd_valid = 0
  - init_busy = 1
- Read latency (base build): re sampled at edge N; data_out and rd_valid=1 are valid after edge N, for one cycle of rd_valid.
- Back-to-back reads: one result per cycle, in issue order.
- Write visibility: a write at edge N is visible to a read issued at edge N+1 or later in both modes. Same-edge visibility follows RDW_MODE.
- Clear duration: init_busy falls after edge DEPTH counted from the first edge with rst low. The first accepted access is on the following edge.

## Configuration
- RAM_OUT_REG_EN defined: adds an output register stage.
  - data_out and rd_valid appear one edge later (read latency 2).
  - Throughput is still one read per cycle.
  - The extra stage resets to 0.
  - A read accepted on the last cycle before rst is asserted is discarded (no rd_valid).
- RAM_OUT_REG_EN undefined: read latency 1, as specified in Timing.

## Test plan
- Reset and clear, ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5: rst for 2 cycles, then low -> init_busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 32'hA5A5A5A5, with rd_valid=1 at latency 1 (2 with RAM_OUT_REG_EN).
- Byte enables: write 32'h11223344 to addr 3 with be=4'b1111, then 32'hAABBCCDD with be=4'b0101 -> read of addr 3 returns 32'h11BB33DD. A write with be=4'b0000 leaves the word unchanged.
- Collision, RDW_MODE=0: addr 5 holds 32'h0; same-cycle we/re to addr 5 with data 32'hDEADBEEF, be=4'b1111 -> data_out=32'h0. The next read of addr 5 returns 32'hDEADBEEF.
- Collision, RDW_MODE=1: addr 5 holds 32'h12345678; same-cycle write of 32'hFFFFFFFF with be=4'b0011 -> data_out=32'h1234FFFF.
- Access during clear: drive we=1 (addr 2, 32'h55) and re=1 while init_busy=1 -> rd_valid stays 0. After the clear, addr 2 reads INIT_VALUE.
- Reset mid-operation: assert rst after 7 clear cycles, and separately while a read is in flight -> data_out=0 and rd_valid=0 the next cycle. init_busy stays 1, and the full DEPTH-cycle sweep reruns from address 0.

Source files
------------

// File: rtl/ram_dp_init.sv
// ram_dp_init: single-clock simple dual-port RAM (one write, one read port)
// with byte-lane write enables, selectable read-during-write behaviour, a
// read-valid strobe and a counter-driven clear engine that sweeps INIT_VALUE
// through every word after reset.
// Optional build macro: RAM_OUT_REG_EN adds an output register stage
// (read latency 2 instead of 1).
module ram_dp_init #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter int unsigned            RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid,
  output logic                      init_busy
);

  localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned           NB       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    rvalid_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [NB-1:0]           mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH-1:0]   rd_merged;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_fire;

  // Next-state and write-port steering: the clear engine owns the write port in CLEAR
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_addr  = cnt_q;
      mem_wdata = INIT_VALUE;
      cnt_d     = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_MAX) begin
        state_d = READY;
      end
    end else begin
      mem_we    = we;
      mem_be    = be;
      mem_addr  = wr_addr;
      mem_wdata = data_in;
    end
  end

  // Read word selection, including same-address write-through merge
  always_comb begin
    rd_old    = mem[rd_addr];
    rd_merged = rd_old;
    for (int unsigned k = 0; k < NB; k++) begin
      if (be[k]) begin
        rd_merged[8*k +: 8] = data_in[8*k +: 8];
      end
    end
    rd_word = rd_old;
    if (RDW_MODE == 1 && we && (wr_addr == rd_addr)) begin
      rd_word = rd_merged;
    end
    rd_fire = re && (state_q == READY);
  end

  // Memory array: byte-lane masked write, no reset on storage
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (mem_be[k]) begin
          mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Clear-engine state, busy flag and first read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == CLEAR);
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        dout_q <= rd_word;
      end
    end
  end

  assign init_busy = busy_q;

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout2_q;
  logic                  rvalid2_q;

  // Extra output stage; reset here drops any read caught in the first stage
  always_ff @(posedge clk) begin
    if (rst) begin
      dout2_q   <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rvalid2_q <= rvalid_q;
      if (rvalid_q) begin
        dout2_q <= dout_q;
      end
    end
  end

  assign data_out = dout2_q;
  assign rd_valid = rvalid2_q;
`else
  assign data_out = dout_q;
  assign rd_valid = rvalid_q;
`endif

endmodule
